squeeze_dump_buffer: RTL and testbench

SQUEEZE_DUMP_BUFFER -- requirements
Module: squeeze_dump_buffer

---
 rtl/squeeze_dump_buffer.sv | 177 +++++++++++++++++
 tb/tb_squeeze_dump_buffer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/squeeze_dump_buffer.sv
// Buffers squeezed rate blocks from the permutation stage and streams them out
// as W-bit words, trimming the final word to the requested output length.
module squeeze_dump_buffer #(
    parameter int W        = 64,
    parameter int RATE_MAX = 1344,
    parameter int SLOTS    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    input  logic [31:0]         output_size,
    input  logic                blk_valid,
    input  logic [RATE_MAX-1:0] blk_data,
    output logic                blk_ready,
    output logic [W-1:0]        data_out,
    output logic [W/8-1:0]      keep_out,
    output logic                valid_out,
    input  logic                ready_in,
    output logic                last_out,
    output logic                busy,
    output logic                done
);

    // state | meaning
    // IDLE  | waiting for start
    // RUN   | accepting blocks and emitting words
    // FLUSH | one-cycle done pulse, then back to IDLE

    localparam int PTR_W   = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int OCC_W   = $clog2(SLOTS + 1);
    localparam int WPB_MAX = RATE_MAX / W;
    localparam int IDX_W   = (WPB_MAX > 1) ? $clog2(WPB_MAX + 1) : 1;
    localparam int KB      = W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t              state;
    logic                mode_q;
    logic [31:0]         size_q;
    logic [32:0]         bits_acc;
    logic [32:0]         bits_out;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [OCC_W-1:0]    occ;
    logic [IDX_W-1:0]    word_idx;
    logic [RATE_MAX-1:0] slot_mem [SLOTS];

    logic [32:0]         rate_bits;
    logic [IDX_W-1:0]    last_idx;
    logic                accept;
    logic                xfer;
    logic                word_last;
    logic                is_last;
    logic [32:0]         rem_bits;
    logic [32:0]         rem_bytes;
    logic [KB-1:0]       keep_raw;
    logic [W-1:0]        word_data;
    logic [RATE_MAX-1:0] cur_slot;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SLOTS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign rate_bits = mode_q ? 33'd1088 : 33'd1344;
    assign last_idx  = mode_q ? IDX_W'(1088 / W - 1) : IDX_W'(1344 / W - 1);

    assign blk_ready = (state == RUN) && (occ < OCC_W'(SLOTS)) && (bits_acc < {1'b0, size_q});
    assign valid_out = (state == RUN) && (occ != '0);
    assign accept    = blk_valid && blk_ready;
    assign xfer      = valid_out && ready_in;
    assign word_last = (word_idx == last_idx);
    assign is_last   = (bits_out + 33'(W)) >= {1'b0, size_q};

    // Only consulted on the last word, where the remainder is at most W bits.
    assign rem_bits  = {1'b0, size_q} - bits_out;
    assign rem_bytes = rem_bits >> 3;

    always_comb begin
        keep_raw = '1;
        if (is_last) begin
            for (int i = 0; i < KB; i++) begin
                keep_raw[i] = (33'(i) < rem_bytes);
            end
        end
    end

    assign cur_slot = slot_mem[rd_ptr];

    always_comb begin
        word_data = '0;
        for (int j = 0; j < WPB_MAX; j++) begin
            if (word_idx == IDX_W'(j)) begin
                word_data = cur_slot[j*W +: W];
            end
        end
    end

    // Gate the word lanes so nothing leaks out while idle or in reset.
    assign data_out = valid_out ? word_data : '0;
    assign keep_out = valid_out ? keep_raw : '0;
    assign last_out = valid_out && is_last;
    assign busy     = (state == RUN);
    assign done     = (state == FLUSH);

    always_ff @(posedge clk) begin
        if (accept) begin
            slot_mem[wr_ptr] <= blk_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mode_q   <= 1'b0;
            size_q   <= '0;
            bits_acc <= '0;
            bits_out <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            word_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q   <= mode;
                        size_q   <= output_size;
                        bits_acc <= '0;
                        bits_out <= '0;
                        wr_ptr   <= '0;
                        rd_ptr   <= '0;
                        occ      <= '0;
                        word_idx <= '0;
                        state    <= (output_size == 32'd0) ? FLUSH : RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        wr_ptr   <= ptr_next(wr_ptr);
                        bits_acc <= bits_acc + rate_bits;
                    end
                    if (xfer) begin
                        bits_out <= bits_out + 33'(W);
                        if (word_last) begin
                            word_idx <= '0;
                            rd_ptr   <= ptr_next(rd_ptr);
                        end else begin
                            word_idx <= word_idx + IDX_W'(1);
                        end
                    end
                    case ({accept, xfer && word_last})
                        2'b10:   occ <= occ + OCC_W'(1);
                        2'b01:   occ <= occ - OCC_W'(1);
                        default: occ <= occ;
                    endcase
                    // Last word out: drop anything still buffered.
                    if (xfer && is_last) begin
                        occ   <= '0;
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_squeeze_dump_buffer.sv
// Directed bench for squeeze_dump_buffer with default parameters (W=64, SLOTS=2).
module tb_squeeze_dump_buffer;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mode;
    logic [31:0]   output_size;
    logic          blk_valid;
    logic [1343:0] blk_data;
    logic          blk_ready;
    logic [63:0]   data_out;
    logic [7:0]    keep_out;
    logic          valid_out;
    logic          ready_in;
    logic          last_out;
    logic          busy;
    logic          done;

    int n_cmp  = 0;
    int n_fail = 0;

    squeeze_dump_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .output_size (output_size),
        .blk_valid   (blk_valid),
        .blk_data    (blk_data),
        .blk_ready   (blk_ready),
        .data_out    (data_out),
        .keep_out    (keep_out),
        .valid_out   (valid_out),
        .ready_in    (ready_in),
        .last_out    (last_out),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mk_word(input int b, input int w);
        return {8'(b), 8'hA5, 16'(w), 32'h1234_5678 ^ 32'(b * 97 + w)};
    endfunction

    function automatic logic [1343:0] mk_blk(input int b);
        logic [1343:0] r;
        r = '0;
        for (int k = 0; k < 21; k++) r[k*64 +: 64] = mk_word(b, k);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"},  data_out, 64'd0);
        chk({tag, "_keep"},  64'(keep_out), 64'd0);
        chk({tag, "_valid"}, 64'(valid_out), 64'd0);
        chk({tag, "_last"},  64'(last_out), 64'd0);
        chk({tag, "_busy"},  64'(busy), 64'd0);
        chk({tag, "_done"},  64'(done), 64'd0);
        chk({tag, "_rdy"},   64'(blk_ready), 64'd0);
    endtask

    // Runs one request with blocks always offered; ready_in held low for the
    // first `stall` cycles. abort_after>0 pulses rst once that many words moved.
    task automatic run_req(input logic m, input int size, input int stall,
                           input int abort_after, input int exp_blocks, input string tag);
        int          wpb;
        int          total;
        int          wc;
        int          bc;
        int          cyc;
        int          dones;
        int          acc3;
        int          w21;
        int          rem;
        logic [7:0]  exp_keep;
        logic [63:0] prev_d;
        logic [7:0]  prev_k;
        logic        prev_l;
        logic        prev_stall;
        logic        aborted;
        wpb = m ? 17 : 21;
        total = (size + 63) / 64;
        wc = 0; bc = 0; cyc = 0; dones = 0; acc3 = -1; w21 = -1;
        prev_d = '0; prev_k = '0; prev_l = 1'b0; prev_stall = 1'b0; aborted = 1'b0;

        @(posedge clk); #1;
        start = 1'b1; mode = m; output_size = 32'(size);
        blk_valid = 1'b1; blk_data = mk_blk(0); ready_in = (stall == 0);
        @(posedge clk); #1;
        start = 1'b0; mode = ~m; output_size = 32'd8;
        chk({tag, "_busy_on"}, 64'(busy), 64'd1);

        while (cyc < 3000) begin
            blk_data = mk_blk(bc);
            ready_in = (cyc >= stall);
            start = 1'b0;
            if (abort_after > 0 && wc == abort_after) begin
                rst = 1'b1;
                blk_valid = 1'b0;
                #1;
                chk_all_zero({tag, "_inrst"});
                @(posedge clk); #1;
                chk_all_zero({tag, "_inrst2"});
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (done) begin
                dones++;
                chk({tag, "_done_busy"},  64'(busy), 64'd0);
                chk({tag, "_done_valid"}, 64'(valid_out), 64'd0);
                break;
            end
            if (cyc == 3) start = 1'b1;
            if (stall > 0 && cyc == stall - 1) begin
                chk({tag, "_stall_blks"}, 64'(bc), 64'd2);
                chk({tag, "_stall_rdy"},  64'(blk_ready), 64'd0);
            end
            if (prev_stall) begin
                chk({tag, "_hold_valid"}, 64'(valid_out), 64'd1);
                chk({tag, "_hold_data"},  data_out, prev_d);
                chk({tag, "_hold_keep"},  64'(keep_out), 64'(prev_k));
                chk({tag, "_hold_last"},  64'(last_out), 64'(prev_l));
            end
            if (valid_out) begin
                if (ready_in) begin
                    rem = size - wc * 64;
                    exp_keep = (rem >= 64) ? 8'hFF : 8'((1 << (rem / 8)) - 1);
                    chk($sformatf("%s_data%0d", tag, wc), data_out, mk_word(wc / wpb, wc % wpb));
                    chk($sformatf("%s_keep%0d", tag, wc), 64'(keep_out), 64'(exp_keep));
                    chk($sformatf("%s_last%0d", tag, wc), 64'(last_out), 64'(wc == total - 1));
                    wc++;
                    if (wc == 21) w21 = cyc;
                end
                prev_stall = !ready_in;
                prev_d = data_out; prev_k = keep_out; prev_l = last_out;
            end else begin
                prev_stall = 1'b0;
            end
            if (exp_blocks > 0 && bc >= exp_blocks)
                chk({tag, "_no_extra_blk"}, 64'(blk_ready), 64'd0);
            if (blk_valid && blk_ready) begin
                bc++;
                if (bc == 3) acc3 = cyc;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        blk_valid = 1'b0;

        if (aborted) begin
            repeat (3) begin
                @(posedge clk); #1;
                chk({tag, "_no_done"}, 64'(done), 64'd0);
            end
        end else begin
            chk({tag, "_timeout"}, 64'(cyc < 3000), 64'd1);
            chk({tag, "_words"},  64'(wc), 64'(total));
            chk({tag, "_blocks"}, 64'(bc), 64'(exp_blocks));
            chk({tag, "_dones"},  64'(dones), 64'd1);
            if (stall > 0) chk({tag, "_third_blk_cycle"}, 64'(acc3), 64'(w21 + 1));
            @(posedge clk); #1;
            chk({tag, "_done_pulse"}, 64'(done), 64'd0);
            chk({tag, "_idle_busy"},  64'(busy), 64'd0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; output_size = '0;
        blk_valid = 1'b0; blk_data = '0; ready_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        run_req(1'b0, 256,  0,  0, 1, "r256");
        run_req(1'b1, 1152, 0,  0, 2, "r1152");
        run_req(1'b0, 104,  0,  0, 1, "r104");
        run_req(1'b0, 4032, 60, 0, 3, "r4032");

        @(posedge clk); #1;
        start = 1'b1; mode = 1'b0; output_size = 32'd0; blk_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("zero_busy", 64'(busy), 64'd0);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_rdy",  64'(blk_ready), 64'd0);
        @(posedge clk); #1;
        chk("zero_done_pulse", 64'(done), 64'd0);
        chk("zero_rdy2", 64'(blk_ready), 64'd0);
        blk_valid = 1'b0;

        run_req(1'b0, 1344, 0, 5, -1, "abort");
        run_req(1'b1, 64,   0, 0, 1,  "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
